// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Tracks the destination registers of in-flight long-latency operations
// (integer divide, FP div/sqrt). Their results reach WB many cycles after EX,
// so normal forwarding cannot cover them. The block keeps one busy bit per
// integer and FP register. It raises stall_id on RAW/WAW hits against those
// registers, and also when another long op would exceed MAX_PENDING.
//
// Ports
//   clk, reset_n                       clock, synchronous active-low reset
//   issue_valid/issue_rd/issue_fp      long op accepted by its unit this cycle
//   wb_valid/wb_rd/wb_fp               long op result written back this cycle
//   id_rs1..3, id_use_rs, id_fp_rs     ID-stage sources, enables, file selects
//   id_rd, id_rd_valid, id_rd_fp       ID-stage destination
//   id_is_long                         ID instruction is itself a long op
//   stall_id                           hold IF/ID, bubble into EX (combinational)
//   int_busy, fp_busy                  registered busy vectors
//   pending_count, sb_full             outstanding op count, count == MAX_PENDING
//   err_spurious_wb, err_double_issue  sticky error flags
module reg_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             issue_fp,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_fp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rs3,
    input  logic [2:0]       id_use_rs,
    input  logic [2:0]       id_fp_rs,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_valid,
    input  logic             id_rd_fp,
    input  logic             id_is_long,
    output logic             stall_id,
    output logic [31:0]      int_busy,
    output logic [31:0]      fp_busy,
    output logic [CNT_W-1:0] pending_count,
    output logic             sb_full,
    output logic             err_spurious_wb,
    output logic             err_double_issue
);

    localparam logic [CNT_W:0] MAX_EXT = (CNT_W+1)'(MAX_PENDING);

    logic [31:0]      int_q, int_d;
    logic [31:0]      fp_q, fp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             err_sw_q, err_sw_d;
    logic             err_di_q, err_di_d;

    // x0 never becomes busy, so integer rd=0 traffic is dropped up front.
    logic iss_ok, wb_ok;
    logic iss_busy, wb_busy;
    logic wb_free, same_reg, cnt_at_max, iss_accept;
    logic [31:0] iss_any_int, iss_any_fp, wb_any_int, wb_any_fp;
    logic [31:0] iss_set_int, iss_set_fp, wb_clr_int, wb_clr_fp;
    logic [31:0] eff_int, eff_fp;
    logic [CNT_W:0] cnt_ext, proj;
    logic src_hit, waw_hit, cap_hit;

    function automatic logic hit(input logic fp, input logic [4:0] r,
                                 input logic [31:0] ei, input logic [31:0] ef);
        return fp ? ef[r] : ((r != 5'd0) && ei[r]);
    endfunction

    always_comb begin
        iss_ok     = issue_valid && (issue_fp || (issue_rd != 5'd0));
        wb_ok      = wb_valid && (wb_fp || (wb_rd != 5'd0));
        iss_busy   = issue_fp ? fp_q[issue_rd] : int_q[issue_rd];
        wb_busy    = wb_fp ? fp_q[wb_rd] : int_q[wb_rd];
        wb_free    = wb_ok && wb_busy;
        same_reg   = iss_ok && wb_ok && (issue_rd == wb_rd) && (issue_fp == wb_fp);
        cnt_at_max = ({1'b0, cnt_q} == MAX_EXT);

        // Re-issue to a busy register is only legal when that register
        // retires in the same cycle; a full scoreboard only accepts an issue
        // when a writeback frees a slot.
        iss_accept = iss_ok && (iss_busy ? (same_reg && wb_free)
                                         : (!cnt_at_max || wb_free));

        iss_any_int = (iss_ok && !issue_fp) ? (32'd1 << issue_rd) : 32'd0;
        iss_any_fp  = (iss_ok &&  issue_fp) ? (32'd1 << issue_rd) : 32'd0;
        wb_any_int  = (wb_ok  && !wb_fp)    ? (32'd1 << wb_rd)    : 32'd0;
        wb_any_fp   = (wb_ok  &&  wb_fp)    ? (32'd1 << wb_rd)    : 32'd0;

        iss_set_int = iss_accept ? iss_any_int : 32'd0;
        iss_set_fp  = iss_accept ? iss_any_fp  : 32'd0;
        wb_clr_int  = wb_free    ? wb_any_int  : 32'd0;
        wb_clr_fp   = wb_free    ? wb_any_fp   : 32'd0;

        int_d    = (int_q & ~wb_clr_int) | iss_set_int;
        fp_d     = (fp_q  & ~wb_clr_fp)  | iss_set_fp;
        cnt_ext  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, iss_accept} - {{CNT_W{1'b0}}, wb_free};
        cnt_d    = cnt_ext[CNT_W-1:0];
        full_d   = (cnt_ext == MAX_EXT);
        err_sw_d = err_sw_q || (wb_ok && !wb_busy);
        err_di_d = err_di_q || (iss_ok && !iss_accept);

        // Writeback is bypassed by the regfile/forwarding, so it frees its
        // register now. The issuing op is still in EX and its result is not
        // yet available, so it counts as busy. Issue wins when both name the
        // same register.
        eff_int = (int_q & ~wb_any_int) | iss_any_int;
        eff_fp  = (fp_q  & ~wb_any_fp)  | iss_any_fp;

        src_hit = (id_use_rs[0] && hit(id_fp_rs[0], id_rs1, eff_int, eff_fp)) ||
                  (id_use_rs[1] && hit(id_fp_rs[1], id_rs2, eff_int, eff_fp)) ||
                  (id_use_rs[2] && hit(id_fp_rs[2], id_rs3, eff_int, eff_fp));
        waw_hit = id_rd_valid && hit(id_rd_fp, id_rd, eff_int, eff_fp);
        proj    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, iss_ok} - {{CNT_W{1'b0}}, wb_free};
        cap_hit = id_is_long && (proj >= MAX_EXT);

        stall_id = src_hit || waw_hit || cap_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            int_q    <= '0;
            fp_q     <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            err_sw_q <= 1'b0;
            err_di_q <= 1'b0;
        end else begin
            int_q    <= int_d;
            fp_q     <= fp_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            err_sw_q <= err_sw_d;
            err_di_q <= err_di_d;
        end
    end

    assign int_busy         = int_q;
    assign fp_busy          = fp_q;
    assign pending_count    = cnt_q;
    assign sb_full          = full_q;
    assign err_spurious_wb  = err_sw_q;
    assign err_double_issue = err_di_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid, issue_fp, wb_valid, wb_fp;
    logic [4:0]  issue_rd, wb_rd, id_rs1, id_rs2, id_rs3, id_rd;
    logic [2:0]  id_use_rs, id_fp_rs;
    logic        id_rd_valid, id_rd_fp, id_is_long;
    logic        stall_id, sb_full, err_spurious_wb, err_double_issue;
    logic [31:0] int_busy, fp_busy;
    logic [2:0]  pending_count;

    reg_scoreboard #(.MAX_PENDING(MAXP), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_fp(issue_fp),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fp(wb_fp),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_use_rs(id_use_rs), .id_fp_rs(id_fp_rs),
        .id_rd(id_rd), .id_rd_valid(id_rd_valid), .id_rd_fp(id_rd_fp),
        .id_is_long(id_is_long),
        .stall_id(stall_id), .int_busy(int_busy), .fp_busy(fp_busy),
        .pending_count(pending_count), .sb_full(sb_full),
        .err_spurious_wb(err_spurious_wb), .err_double_issue(err_double_issue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ib;
        logic [31:0] fb;
        int          cnt;
        bit          full;
        bit          sw;
        bit          di;
    } exp_t;

    exp_t exp_q[$];
    bit   stall_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    // reference model state
    bit [31:0] m_int, m_fp;
    int        m_cnt;
    bit        m_sw, m_di;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv)
            $display("FAIL %s: got %h want %h at %0t", tag, obs, expv, $time);
        else
            n_pass++;
    endtask

    function automatic bit m_qual(input bit fp, input logic [4:0] r);
        return fp || (r != 5'd0);
    endfunction

    function automatic bit m_reg(input bit fp, input logic [4:0] r);
        return fp ? m_fp[r] : m_int[r];
    endfunction

    function automatic bit m_eff(input bit fp, input logic [4:0] r);
        bit b;
        if (!m_qual(fp, r)) return 1'b0;
        b = m_reg(fp, r);
        if (wb_valid && m_qual(wb_fp, wb_rd) && wb_fp == fp && wb_rd == r) b = 1'b0;
        if (issue_valid && m_qual(issue_fp, issue_rd) && issue_fp == fp && issue_rd == r) b = 1'b1;
        return b;
    endfunction

    function automatic bit model_stall();
        bit s = 1'b0;
        int iq, fr;
        logic [4:0] rs [3];
        rs[0] = id_rs1; rs[1] = id_rs2; rs[2] = id_rs3;
        for (int i = 0; i < 3; i++)
            if (id_use_rs[i] && m_eff(id_fp_rs[i], rs[i])) s = 1'b1;
        if (id_rd_valid && m_eff(id_rd_fp, id_rd)) s = 1'b1;
        iq = (issue_valid && m_qual(issue_fp, issue_rd)) ? 1 : 0;
        fr = (wb_valid && m_qual(wb_fp, wb_rd) && m_reg(wb_fp, wb_rd)) ? 1 : 0;
        if (id_is_long && (m_cnt + iq - fr >= MAXP)) s = 1'b1;
        return s;
    endfunction

    task automatic model_step();
        bit [31:0] ni, nf;
        int nc;
        bit wq, iq, freeing, ob;
        exp_t e;
        if (!reset_n) begin
            m_int = '0; m_fp = '0; m_cnt = 0; m_sw = 0; m_di = 0;
        end else begin
            ni = m_int; nf = m_fp; nc = m_cnt;
            wq = wb_valid && m_qual(wb_fp, wb_rd);
            iq = issue_valid && m_qual(issue_fp, issue_rd);
            freeing = wq && m_reg(wb_fp, wb_rd);
            if (wq) begin
                if (freeing) begin
                    if (wb_fp) nf[wb_rd] = 1'b0; else ni[wb_rd] = 1'b0;
                    nc--;
                end else begin
                    m_sw = 1'b1;
                end
            end
            if (iq) begin
                ob = m_reg(issue_fp, issue_rd);
                if (ob) begin
                    if (freeing && wb_rd == issue_rd && wb_fp == issue_fp) begin
                        if (issue_fp) nf[issue_rd] = 1'b1; else ni[issue_rd] = 1'b1;
                        nc++;
                    end else begin
                        m_di = 1'b1;
                    end
                end else if (m_cnt == MAXP && !freeing) begin
                    m_di = 1'b1;
                end else begin
                    if (issue_fp) nf[issue_rd] = 1'b1; else ni[issue_rd] = 1'b1;
                    nc++;
                end
            end
            m_int = ni; m_fp = nf; m_cnt = nc;
        end
        e.ib = m_int; e.fb = m_fp; e.cnt = m_cnt;
        e.full = reset_n ? (m_cnt == MAXP) : 1'b0;
        e.sw = m_sw; e.di = m_di;
        exp_q.push_back(e);
    endtask

    // inputs are already set (after a negedge); check stall, clock, check state
    task automatic tick();
        exp_t o;
        bit s;
        #1;
        stall_q.push_back(model_stall());
        model_step();
        s = stall_q.pop_front();
        check("stall_id", {31'd0, stall_id}, {31'd0, s});
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        check("int_busy", int_busy, o.ib);
        check("fp_busy", fp_busy, o.fb);
        check("pending_count", {29'd0, pending_count}, 32'(o.cnt));
        check("sb_full", {31'd0, sb_full}, {31'd0, o.full});
        check("err_spurious_wb", {31'd0, err_spurious_wb}, {31'd0, o.sw});
        check("err_double_issue", {31'd0, err_double_issue}, {31'd0, o.di});
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_fp = 0;
        wb_valid = 0; wb_rd = 0; wb_fp = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs3 = 0; id_use_rs = 0; id_fp_rs = 0;
        id_rd = 0; id_rd_valid = 0; id_rd_fp = 0; id_is_long = 0;
    endtask

    task automatic iss(input logic [4:0] r, input logic fp);
        issue_valid = 1; issue_rd = r; issue_fp = fp;
    endtask

    task automatic wb(input logic [4:0] r, input logic fp);
        wb_valid = 1; wb_rd = r; wb_fp = fp;
    endtask

    task automatic do_reset();
        reset_n = 0; tick(); reset_n = 1;
    endtask

    initial begin
        idle();
        reset_n = 0;
        m_int = '0; m_fp = '0; m_cnt = 0; m_sw = 0; m_di = 0;
        @(negedge clk);
        tick(); tick();
        reset_n = 1;

        // x5 long op, source reads stall until the wb cycle
        iss(5, 0); tick(); idle();
        for (int i = 0; i < 3; i++) begin
            id_rs1 = 5; id_use_rs = 3'b001; tick();
        end
        id_rs1 = 5; id_use_rs = 3'b001; wb(5, 0); tick(); idle();
        tick();

        // x0 ignored, f0 tracked
        iss(0, 0); id_rs1 = 0; id_use_rs = 3'b001; tick(); idle();
        iss(0, 1); id_rs1 = 0; id_use_rs = 3'b001; id_fp_rs = 3'b001; tick(); idle();
        wb(0, 1); tick(); idle();

        // file separation and WAW
        iss(7, 0); tick(); idle();
        id_rs1 = 7; id_use_rs = 3'b001; id_fp_rs = 3'b001; tick(); idle();
        id_rd = 7; id_rd_valid = 1; tick(); idle();
        id_rs3 = 7; id_use_rs = 3'b100; tick(); idle();
        wb(7, 0); tick(); idle();

        // capacity
        for (int r = 1; r <= 4; r++) begin iss(5'(r), 0); tick(); end
        idle();
        id_is_long = 1; tick();
        wb(2, 0); tick(); idle();
        iss(2, 0); tick();
        iss(6, 0); tick(); idle();
        for (int r = 1; r <= 4; r++) begin wb(5'(r), 0); tick(); end
        idle();

        // same-cycle issue+wb, spurious wb
        do_reset();
        iss(9, 0); tick();
        iss(9, 0); wb(9, 0); id_rs2 = 9; id_use_rs = 3'b010; tick(); idle();
        wb(10, 0); tick(); idle();
        tick(); tick();

        // reset discards pending work
        do_reset();
        iss(11, 0); tick(); iss(12, 0); tick(); iss(3, 1); tick();
        iss(13, 0); reset_n = 0; tick(); reset_n = 1; idle();
        tick();

        // random traffic over a few registers
        for (int n = 0; n < 400; n++) begin
            reset_n     = ($urandom_range(0, 59) != 0);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 4));
            issue_fp    = 1'($urandom_range(0, 1));
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_rd       = 5'($urandom_range(0, 4));
            wb_fp       = 1'($urandom_range(0, 1));
            id_rs1      = 5'($urandom_range(0, 4));
            id_rs2      = 5'($urandom_range(0, 4));
            id_rs3      = 5'($urandom_range(0, 4));
            id_use_rs   = 3'($urandom_range(0, 7));
            id_fp_rs    = 3'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 4));
            id_rd_valid = 1'($urandom_range(0, 1));
            id_rd_fp    = 1'($urandom_range(0, 1));
            id_is_long  = 1'($urandom_range(0, 1));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks destination registers of in-flight long-latency operations: integer divide and FP div/sqrt.
- These results leave EX but arrive at WB many cycles later, so EX/MEM and MEM/WB forwarding cannot cover them.
- Holds one busy bit per integer register and one per FP register. Stalls the ID stage on RAW or WAW conflicts against those registers.
- Bounds the number of outstanding long-latency ops.
- Sits beside the hazard-detection logic. Its stall output is ORed into the ID/IF stall.

Parameters:
MAX_PENDING, 4, maximum simultaneously outstanding long-latency ops (1..31)
CNT_W, 3, width of pending_count; must hold MAX_PENDING

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
issue_valid  input  1  long-latency op accepted by its unit this cycle
issue_rd  input  5  destination register of the issuing op
issue_fp  input  1  1 = destination is in the FP file, 0 = integer
wb_valid  input  1  long-latency result written back this cycle
wb_rd  input  5  destination register of the writeback
wb_fp  input  1  1 = FP file, 0 = integer
id_rs1  input  5  ID-stage source 1
id_rs2  input  5  ID-stage source 2
id_rs3  input  5  ID-stage source 3 (FMA)
id_use_rs  input  3  per-source valid; bit0 = rs1, bit1 = rs2, bit2 = rs3
id_fp_rs  input  3  per-source file select; 1 = FP
id_rd  input  5  ID-stage destination register
id_rd_valid  input  1  ID instruction writes a register
id_rd_fp  input  1  ID destination is in the FP file
id_is_long  input  1  ID instruction is itself a long-latency op
stall_id  output  1  hold IF/ID; insert bubble into EX
int_busy  output  32  integer busy vector (bit 0 always 0)
fp_busy  output  32  FP busy vector
pending_count  output  CNT_W  number of outstanding ops
sb_full  output  1  pending_count == MAX_PENDING
err_spurious_wb  output  1  sticky: writeback to a non-busy register
err_double_issue  output  1  sticky: issue to an already-busy register

Behaviour:
Reset
- All clocked state is sampled on the rising edge of clk.
- reset_n=0 at an edge forces int_busy=0, fp_busy=0, pending_count=0 and both error flags to 0.
- Reset overrides issue and wb in the same cycle.
- Reset mid-operation discards all pending state; the core must flush the long-latency units concurrently.
- Outputs while in reset:
  - sb_full=0.
  - stall_id is still computed combinationally from the live issue/ID inputs.

Qualification
- An integer issue or wb with rd=0 is ignored entirely: no bit change, no count change, no error.
- FP register f0 is tracked normally.
- The two files are independent: matching requires equal index and equal file select.

State update per edge (reset_n=1)
- wb to a busy register: clear its bit and decrement the count.
- wb to a non-busy register: set err_spurious_wb; no state change.
- issue to a non-busy register: set its bit and increment the count.
- issue to a busy register:
  - If a wb to the same register occurs in the same cycle: the bit stays 1 and the count is unchanged; this is legal.
  - Otherwise: set err_double_issue; the bit stays 1 and the count is unchanged.
- Simultaneous issue and wb to different registers: both apply, so the count is unchanged.
- Issue when pending_count == MAX_PENDING and no wb this cycle: set err_double_issue; ignore the issue.
- The count never wraps.
- Error flags are sticky until reset.

stall_id (combinational)
- Effective busy = registered busy, plus the register of issue_valid this cycle, minus the register of wb_valid this cycle.
  - The wb bypass exists because regfile write-through and forwarding supply the value.
  - The issue bypass exists because the issuing op is still in EX and its result is not forwardable.
  - If issue and wb name the same register in the same cycle, that register is busy.
- stall_id=1 if any of the following holds:
  - Any enabled source hits an effective-busy register in its file (an integer source 0 never hits).
  - WAW: id_rd_valid=1 and id_rd hits an effective-busy register in its file.
  - Capacity: id_is_long=1 and (pending_count + issue_valid − freeing wb_valid) ≥ MAX_PENDING. A wb counts as freeing only if it clears a busy bit, i.e. it is not a spurious wb.
- There is no internal latency on stall_id. The busy vectors and count update one cycle after the issue/wb.

sb_full
- Registered compare of the updated count against MAX_PENDING.

Test Plan:
- Reset, then issue int x5, wb x5 four cycles later -> int_busy[5]=1 for cycles 1–4 after issue; pending_count goes 1 then 0; stall_id=1 for id_rs1=5 until the wb cycle, and 0 in the wb cycle itself (bypass).
- Issue int rd=0 with id_rs1=0 -> no busy bit, count stays 0, stall_id=0. Issue FP f0 with id_fp_rs=001, id_rs1=0 -> stall_id=1 and fp_busy[0]=1.
- Integer x7 busy, ID reads FP f7 with id_fp_rs=001 -> stall_id=0. ID writes int x7 with id_rd_valid=1 -> stall_id=1 (WAW).
- MAX_PENDING=4: issue to x1..x4 -> sb_full=1; id_is_long=1 -> stall_id=1; in the cycle wb x2 arrives -> stall_id=0; a fifth issue with no wb -> err_double_issue=1, count stays 4.
- Issue and wb to x9 in the same cycle while x9 is busy -> int_busy[9] stays 1, count unchanged, no error. wb to non-busy x10 -> err_spurious_wb=1, held until reset.
- Three ops pending, then reset_n=0 for one edge together with issue_valid=1 -> all busy bits 0, count 0, flags 0 on the next cycle.
